// File: rtl/universal_shift_reg_if.sv
// Operation/data bundle for universal_shift_reg.
// The master drives the control and data inputs; the slave returns Q, SerOut and Tc.
interface universal_shift_reg_if #(
   parameter int WIDTH = 8
);
   logic             En;
   logic [2:0]       Mode;
   logic [WIDTH-1:0] D;
   logic             SerIn;
   logic [WIDTH-1:0] Q;
   logic             SerOut;
   logic             Tc;

   modport master (output En, Mode, D, SerIn, input Q, SerOut, Tc);
   modport slave  (input En, Mode, D, SerIn, output Q, SerOut, Tc);
endinterface

// File: rtl/universal_shift_reg.sv
// WIDTH-bit load/shift/rotate/count register: 1-cycle latency, all outputs registered, no backpressure (En=0 holds).
// Define UREG_SAT_EN to make the count modes saturate instead of wrapping.
module universal_shift_reg #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input logic                 Clk,
   input logic                 Rst,
   universal_shift_reg_if.slave bus
);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] q_r;
   logic             ser_r;
   logic             tc_r;
   logic             at_max;
   logic             at_min;

   assign at_max = &q_r;
   assign at_min = ~|q_r;

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         q_r   <= RST_VAL;
         ser_r <= 1'b0;
         tc_r  <= 1'b0;
      end else begin
         // Tc is a pulse: cleared on every cycle that is not a limit count.
         tc_r <= 1'b0;
         if (bus.En) begin
            case (bus.Mode)
               3'b001: q_r <= bus.D;
               3'b010: begin
                  q_r   <= {q_r[WIDTH-2:0], bus.SerIn};
                  ser_r <= q_r[WIDTH-1];
               end
               3'b011: begin
                  q_r   <= {bus.SerIn, q_r[WIDTH-1:1]};
                  ser_r <= q_r[0];
               end
               3'b100: begin
                  q_r   <= {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                  ser_r <= q_r[WIDTH-1];
               end
               3'b101: begin
                  q_r   <= {q_r[0], q_r[WIDTH-1:1]};
                  ser_r <= q_r[0];
               end
               3'b110: begin
                  tc_r <= at_max;
`ifdef UREG_SAT_EN
                  if (!at_max) q_r <= q_r + ONE;
`else
                  q_r <= q_r + ONE;
`endif
               end
               3'b111: begin
                  tc_r <= at_min;
`ifdef UREG_SAT_EN
                  if (!at_min) q_r <= q_r - ONE;
`else
                  q_r <= q_r - ONE;
`endif
               end
               default: q_r <= q_r;
            endcase
         end
      end
   end

   assign bus.Q      = q_r;
   assign bus.SerOut = ser_r;
   assign bus.Tc     = tc_r;
endmodule

// File: tb/tb_universal_shift_reg.sv
// Randomised bench for universal_shift_reg with an arithmetic reference model and literal directed checks.
module tb_universal_shift_reg;
   localparam int W = 8;
   localparam int M = 1 << W;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   universal_shift_reg_if #(.WIDTH(W)) bus ();

   universal_shift_reg #(.WIDTH(W), .RST_VAL('0)) dut (
      .Clk (clk),
      .Rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model: Q as an integer in [0, 2^W), updated from the sampled inputs.
   int mq = 0;
   int ms = 0;
   int mt = 0;
   bit mvld = 1'b0;

   always @(posedge clk) begin
      int q, s, e, mo, d;
      q  = mq;
      s  = int'(bus.SerIn);
      e  = int'(bus.En);
      mo = int'(bus.Mode);
      d  = int'(bus.D);
      if (!rst) begin
         mq = 0; ms = 0; mt = 0; mvld = 1'b1;
      end else begin
         mt = 0;
         if (e == 1) begin
            case (mo)
               1: mq = d;
               2: begin mq = (q * 2 + s) % M;           ms = q / (M / 2); end
               3: begin mq = q / 2 + s * (M / 2);       ms = q % 2;       end
               4: begin mq = (q * 2) % M + q / (M / 2); ms = q / (M / 2); end
               5: begin mq = q / 2 + (q % 2) * (M / 2); ms = q % 2;       end
               6: begin
                  mt = (q == M - 1) ? 1 : 0;
`ifdef UREG_SAT_EN
                  mq = (q == M - 1) ? q : q + 1;
`else
                  mq = (q + 1) % M;
`endif
               end
               7: begin
                  mt = (q == 0) ? 1 : 0;
`ifdef UREG_SAT_EN
                  mq = (q == 0) ? 0 : q - 1;
`else
                  mq = (q + M - 1) % M;
`endif
               end
               default: ;
            endcase
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (mvld) begin
         chk("q", int'(bus.Q), mq);
         chk("serout", int'(bus.SerOut), ms);
         chk("tc", int'(bus.Tc), mt);
      end
   end

   task automatic op(input bit r, input bit e, input logic [2:0] m,
                     input logic [W-1:0] d, input bit s);
      rst       = r;
      bus.En    = e;
      bus.Mode  = m;
      bus.D     = d;
      bus.SerIn = s;
      @(posedge clk);
      #2;
   endtask

   task automatic exp_q(input string name, input int q, input int tc);
      chk({name, ".q"}, int'(bus.Q), q);
      chk({name, ".tc"}, int'(bus.Tc), tc);
   endtask

   initial begin
      bus.En = 1'b0; bus.Mode = 3'b000; bus.D = '0; bus.SerIn = 1'b0;
      @(posedge clk); #2;

      // Reset beats a pending load.
      op(0, 1, 3'b001, 8'hFF, 0);
      exp_q("rst", 'h00, 0);
      chk("rst.ser", int'(bus.SerOut), 0);
      op(1, 1, 3'b001, 8'hA5, 0);
      exp_q("load", 'hA5, 0);

      op(1, 1, 3'b001, 8'h81, 0);
      op(1, 1, 3'b010, 8'h00, 0);
      exp_q("shl", 'h02, 0);
      chk("shl.ser", int'(bus.SerOut), 1);
      op(1, 1, 3'b011, 8'h00, 1);
      exp_q("shr", 'h81, 0);
      chk("shr.ser", int'(bus.SerOut), 0);

      op(1, 1, 3'b101, 8'h00, 0);
      chk("ror1.q", int'(bus.Q), 'hC0);
      chk("ror1.ser", int'(bus.SerOut), 1);
      op(1, 1, 3'b101, 8'h00, 0);
      chk("ror2.q", int'(bus.Q), 'h60);
      chk("ror2.ser", int'(bus.SerOut), 0);
      op(1, 1, 3'b100, 8'h00, 0);
      chk("rol.q", int'(bus.Q), 'hC0);
      chk("rol.ser", int'(bus.SerOut), 0);
      // SerOut holds through a load.
      op(1, 1, 3'b001, 8'h3C, 1);
      chk("ser_hold", int'(bus.SerOut), 0);

      op(1, 1, 3'b001, 8'hFE, 0);
      op(1, 1, 3'b110, 8'h00, 0); exp_q("up1", 'hFF, 0);
`ifdef UREG_SAT_EN
      op(1, 1, 3'b110, 8'h00, 0); exp_q("up2", 'hFF, 1);
      op(1, 1, 3'b110, 8'h00, 0); exp_q("up3", 'hFF, 1);
`else
      op(1, 1, 3'b110, 8'h00, 0); exp_q("up2", 'h00, 1);
      op(1, 1, 3'b110, 8'h00, 0); exp_q("up3", 'h01, 0);
`endif

      op(1, 1, 3'b001, 8'h01, 0);
      op(1, 1, 3'b111, 8'h00, 0); exp_q("dn1", 'h00, 0);
`ifdef UREG_SAT_EN
      op(1, 1, 3'b111, 8'h00, 0); exp_q("dn2", 'h00, 1);
`else
      op(1, 1, 3'b111, 8'h00, 0); exp_q("dn2", 'hFF, 1);
`endif
      // Tc must drop when counting stops.
      op(1, 0, 3'b111, 8'h00, 0); chk("tc_clr", int'(bus.Tc), 0);

      op(1, 1, 3'b001, 8'h10, 0);
      op(1, 1, 3'b110, 8'h00, 0); exp_q("en1", 'h11, 0);
      op(1, 0, 3'b001, 8'h77, 0); exp_q("en0", 'h11, 0);
      op(1, 1, 3'b110, 8'h00, 0); exp_q("en1b", 'h12, 0);
      op(0, 1, 3'b110, 8'h00, 0); exp_q("midrst", 'h00, 0);
      op(1, 1, 3'b110, 8'h00, 0); exp_q("resume", 'h01, 0);

      for (int i = 0; i < 3000; i++) begin
         logic [W-1:0] d;
         int sel;
         sel = int'($urandom_range(0, 3));
         d = (sel == 0) ? 8'hFF : (sel == 1) ? 8'h00 : W'($urandom);
         op(($urandom_range(0, 99) != 0), ($urandom_range(0, 4) != 0),
            3'($urandom), d, 1'($urandom));
      end

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised successor to the team's fixed 8-bit register: a WIDTH-bit register with synchronous load, shift, rotate and up/down count modes, a serial data path and a registered terminal-count flag. It is the general-purpose storage/sequencing element for the datapath labs. It replaces plain load-only registers wherever a shifter, counter or serial converter is needed.

## Interface
- WIDTH, 8, register width in bits (≥2)
- RST_VAL, {WIDTH{1'b0}}, value loaded into Q on reset

- Clk  in  1  clock; all state changes on rising edge
- Rst  in  1  reset; synchronous, active-low (Rst=0 at a rising Clk edge resets)
- En  in  1  operation enable; 0 = hold
- Mode  in  3  operation select (see Operation)
- D  in  WIDTH  parallel load data
- SerIn  in  1  serial input bit for shift modes
- Q  out  WIDTH  register contents
- SerOut  out  1  last bit shifted or rotated out (registered)
- Tc  out  1  terminal-count pulse (registered)

## Operation
- Reset (Rst=0 at edge): Q←RST_VAL, SerOut←0, Tc←0. Reset has priority over En and Mode.
- En=0: Q and SerOut hold; Tc←0.
- En=1, Mode decode:
  - 000 hold: Q holds; SerOut holds.
  - 001 load: Q←D.
  - 010 shift left: Q←{Q[WIDTH-2:0],SerIn}; SerOut←Q[WIDTH-1].
  - 011 shift right: Q←{SerIn,Q[WIDTH-1:1]}; SerOut←Q[0].
  - 100 rotate left: Q←{Q[WIDTH-2:0],Q[WIDTH-1]}; SerOut←Q[WIDTH-1].
  - 101 rotate right: Q←{Q[0],Q[WIDTH-1:1]}; SerOut←Q[0].
  - 110 count up: Q←Q+1, modulo 2^WIDTH.
  - 111 count down: Q←Q−1, modulo 2^WIDTH.
- SerOut changes only in modes 010–101; it holds in all other cycles.
- Tc←1 only in a count cycle whose operand is at the limit: Q=all-ones for up, Q=0 for down. Otherwise Tc←0 every cycle, so Tc is a single-cycle pulse per limit event.
- Unsigned arithmetic throughout; no carry port; Tc is the only overflow indication.

## Timing
- All outputs registered; no combinational path from any input to any output.
- Latency 1 cycle: an operation sampled at edge N is visible on Q/SerOut/Tc after edge N.
- Mode and D are sampled only when En=1. Their values while En=0 have no effect.
- Reset asserted mid-sequence (e.g. during counting) takes effect at that edge. The next operation starts from RST_VAL on the first edge with Rst=1.
- Tc and the wrapped or saturated Q value appear on the same edge.

## Configuration
- UREG_SAT_EN defined: count modes saturate. Up at all-ones and down at 0 leave Q unchanged and still pulse Tc.
- UREG_SAT_EN undefined (default): count modes wrap as specified above.
- Shift, rotate, load and SerOut behaviour are identical in both builds.

## Test plan
- WIDTH=8, RST_VAL=0: Rst=0 for one edge with En=1, Mode=001, D=8'hFF → Q=8'h00, SerOut=0, Tc=0. Then Rst=1, load D=8'hA5 → Q=8'hA5 after one edge.
- Q=8'h81, En=1, shift left with SerIn=0 → Q=8'h02, SerOut=1. Then shift right with SerIn=1 → Q=8'h81, SerOut=0.
- Q=8'h81, rotate right twice → Q=8'hC0 then 8'h60, SerOut=1 then 0. Rotate left once → Q=8'hC0, SerOut=0.
- Load 8'hFE, count up 3 edges → Q=FF, 00, 01 with Tc=0, 1, 0. Under UREG_SAT_EN → Q=FF, FF, FF with Tc=0, 1, 1.
- Load 8'h01, count down 2 edges → Q=00, FF with Tc=0, 1. Under UREG_SAT_EN → Q=00, 00 with Tc=0, 1.
- Counting from 8'h10 with En toggled 1,0,1 → Q=11, 11, 12 with Tc=0. Rst=0 mid-count → Q=00 at that edge, then count resumes 01.
